// File: rtl/card_if.sv
// Bundle between the baccarat statemachine and the card datapath: load strobes
// and test-deal controls in one direction, hand contents and scores in the other.
interface card_if;
  logic       load_pcard1;
  logic       load_pcard2;
  logic       load_pcard3;
  logic       load_dcard1;
  logic       load_dcard2;
  logic       load_dcard3;
  logic       test_card_en;
  logic [3:0] test_card;

  logic [3:0] pcard1;
  logic [3:0] pcard2;
  logic [3:0] pcard3;
  logic [3:0] dcard1;
  logic [3:0] dcard2;
  logic [3:0] dcard3;
  logic [3:0] pscore;
  logic [3:0] dscore;
  logic [3:0] pcard3_out;
  logic [2:0] cards_dealt;

  modport master (
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output test_card_en, test_card,
    input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    input  pscore, dscore, pcard3_out, cards_dealt
  );

  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  test_card_en, test_card,
    output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
    output pscore, dscore, pcard3_out, cards_dealt
  );
endinterface

// File: rtl/card_datapath.sv
// Baccarat card datapath: free-running dealer counter, six write-once hand
// registers, and combinational hand scores / card count derived from them.
module card_datapath #(
  parameter int CARD_MAX = 13
) (
  input  logic   slow_clock,
  input  logic   resetb,
  card_if.slave  bus
);

  localparam logic [3:0] CARD_MAX_L = 4'(CARD_MAX);

  // Slot order: 0..2 = player cards 1..3, 3..5 = dealer cards 1..3.
  localparam int NUM_SLOTS = 6;

  logic [3:0]                  counter;
  logic [NUM_SLOTS-1:0]        load_vec;
  logic [NUM_SLOTS-1:0][3:0]   cards_q;
  logic [3:0]                  deal_raw;
  logic [3:0]                  deal;
  logic [2:0]                  dealt_count;

  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
  endfunction

  // Three values of at most 9 sum to at most 27, so two conditional
  // subtractions are enough to reduce mod 10.
  function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                            input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [4:0] sum;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20)      sum = sum - 5'd20;
    else if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:0];
  endfunction

  assign load_vec = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  // Out-of-range forced ranks are dealt as an ace so a hand never holds garbage.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    deal_raw = bus.test_card_en ? bus.test_card : counter;
    deal     = deal_raw;
    if (deal_raw == 4'd0 || deal_raw > CARD_MAX_L) deal = 4'd1;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the card slots are reset explicitly because 0 is the "empty" marker the load guard relies on.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      counter <= 4'd1;
      cards_q <= '0;
    end else begin
      counter <= (counter >= CARD_MAX_L) ? 4'd1 : counter + 4'd1;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (load_vec[i] && cards_q[i] == 4'd0) cards_q[i] <= deal;
      end
    end
  end

  always_comb begin
    dealt_count = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (cards_q[i] != 4'd0) dealt_count = dealt_count + 3'd1;
    end
  end

  assign bus.pcard1      = cards_q[0];
  assign bus.pcard2      = cards_q[1];
  assign bus.pcard3      = cards_q[2];
  assign bus.dcard1      = cards_q[3];
  assign bus.dcard2      = cards_q[4];
  assign bus.dcard3      = cards_q[5];
  assign bus.pcard3_out  = cards_q[2];
  assign bus.pscore      = hand_score(cards_q[0], cards_q[1], cards_q[2]);
  assign bus.dscore      = hand_score(cards_q[3], cards_q[4], cards_q[5]);
  assign bus.cards_dealt = dealt_count;

endmodule

// File: tb/tb_card_datapath.sv
// Scoreboard bench for card_datapath: a driver feeds directed and random deals
// into a hand model and queues expectations; a monitor compares each cycle.
module tb_card_datapath;

  typedef struct packed {
    logic [23:0] cards;   // {d3,d2,d1,p3,p2,p1}
    logic [3:0]  ps;
    logic [3:0]  ds;
    logic [3:0]  p3o;
    logic [2:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // Hand model: rank held in each slot, and edges seen since the last reset.
  int   m_cards[6];
  int   m_edges;

  card_if bus();

  card_datapath #(.CARD_MAX(13)) dut (
    .slow_clock (clk),
    .resetb     (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rank_value(input int r);
    return (r >= 1 && r <= 9) ? r : 0;
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    int   ps = 0;
    int   ds = 0;
    int   cnt = 0;
    for (int i = 0; i < 3; i++) ps += rank_value(m_cards[i]);
    for (int i = 3; i < 6; i++) ds += rank_value(m_cards[i]);
    for (int i = 0; i < 6; i++) begin
      e.cards[i*4 +: 4] = 4'(m_cards[i]);
      if (m_cards[i] != 0) cnt++;
    end
    e.ps  = 4'(ps % 10);
    e.ds  = 4'(ds % 10);
    e.p3o = 4'(m_cards[2]);
    e.cnt = 3'(cnt);
    return e;
  endfunction

  task automatic model_step(input logic r, input logic [5:0] ld, input logic en,
                            input logic [3:0] tc);
    int deal;
    if (r) begin
      foreach (m_cards[i]) m_cards[i] = 0;
      m_edges = 0;
    end else begin
      if (en) deal = (tc == 0 || tc > 13) ? 1 : int'(tc);
      else    deal = (m_edges % 13) + 1;
      for (int i = 0; i < 6; i++)
        if (ld[i] && m_cards[i] == 0) m_cards[i] = deal;
      m_edges++;
    end
  endtask

  // Applies one cycle of inputs just after a falling edge and queues the
  // hand state expected after the following rising edge.
  task automatic drive(input logic r, input logic [5:0] ld, input logic en,
                       input logic [3:0] tc);
    @(negedge clk);
    #1;
    rst              = r;
    bus.load_pcard1  = ld[0];
    bus.load_pcard2  = ld[1];
    bus.load_pcard3  = ld[2];
    bus.load_dcard1  = ld[3];
    bus.load_dcard2  = ld[4];
    bus.load_dcard3  = ld[5];
    bus.test_card_en = en;
    bus.test_card    = tc;
    model_step(r, ld, en, tc);
    exp_q.push_back(model_outputs());
  endtask

  task automatic idle();
    drive(1'b0, 6'b0, 1'b0, 4'd0);
  endtask

  // Waits past the edge that applies the last drive, for direct spot checks.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every falling edge the registered outputs are compared with the
  // oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cards", 32'({bus.dcard3, bus.dcard2, bus.dcard1,
                            bus.pcard3, bus.pcard2, bus.pcard1}), 32'(e.cards));
        check("pscore",      32'(bus.pscore),      32'(e.ps));
        check("dscore",      32'(bus.dscore),      32'(e.ds));
        check("pcard3_out",  32'(bus.pcard3_out),  32'(e.p3o));
        check("cards_dealt", 32'(bus.cards_dealt), 32'(e.cnt));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.load_pcard1 = 1'b0; bus.load_pcard2 = 1'b0; bus.load_pcard3 = 1'b0;
    bus.load_dcard1 = 1'b0; bus.load_dcard2 = 1'b0; bus.load_dcard3 = 1'b0;
    bus.test_card_en = 1'b0; bus.test_card = 4'd0;
    foreach (m_cards[i]) m_cards[i] = 0;
    m_edges = 0;

    // Reset held two cycles: everything empty.
    drive(1'b1, 6'b0, 1'b0, 4'd0);
    drive(1'b1, 6'b0, 1'b0, 4'd0);
    after_edge();
    check("reset_dealt",  32'(bus.cards_dealt), 32'd0);
    check("reset_pscore", 32'(bus.pscore), 32'd0);
    check("reset_dscore", 32'(bus.dscore), 32'd0);

    // Counter sequence: deal from the counter on the k-th edge after reset.
    for (int k = 1; k <= 14; k++) begin
      drive(1'b1, 6'b0, 1'b0, 4'd0);
      for (int j = 1; j < k; j++) idle();
      drive(1'b0, 6'b000001, 1'b0, 4'd0);
      after_edge();
      check($sformatf("counter_edge%0d", k), 32'(bus.pcard1), 32'((k - 1) % 13 + 1));
    end

    // Forced deals: p1=3, d1=5, p2=4, d2=2.
    drive(1'b1, 6'b0, 1'b0, 4'd0);
    drive(1'b0, 6'b000001, 1'b1, 4'd3);
    drive(1'b0, 6'b001000, 1'b1, 4'd5);
    drive(1'b0, 6'b000010, 1'b1, 4'd4);
    drive(1'b0, 6'b010000, 1'b1, 4'd2);
    after_edge();
    check("forced_pscore", 32'(bus.pscore), 32'd7);
    check("forced_dscore", 32'(bus.dscore), 32'd7);
    check("forced_dealt",  32'(bus.cards_dealt), 32'd4);

    // Face cards count as zero.
    drive(1'b1, 6'b0, 1'b0, 4'd0);
    drive(1'b0, 6'b000001, 1'b1, 4'd13);
    drive(1'b0, 6'b000010, 1'b1, 4'd9);
    drive(1'b0, 6'b000100, 1'b1, 4'd12);
    drive(1'b0, 6'b001000, 1'b1, 4'd8);
    drive(1'b0, 6'b010000, 1'b1, 4'd7);
    drive(1'b0, 6'b100000, 1'b1, 4'd9);
    after_edge();
    check("face_pscore",  32'(bus.pscore), 32'd9);
    check("face_dscore",  32'(bus.dscore), 32'd4);
    check("face_pcard3",  32'(bus.pcard3_out), 32'd12);
    check("face_dealt",   32'(bus.cards_dealt), 32'd6);

    // Overwrite guard and simultaneous strobes.
    drive(1'b1, 6'b0, 1'b0, 4'd0);
    drive(1'b0, 6'b000001, 1'b1, 4'd6);
    drive(1'b0, 6'b000001, 1'b1, 4'd2);
    after_edge();
    check("guard_pcard1", 32'(bus.pcard1), 32'd6);
    drive(1'b0, 6'b100100, 1'b1, 4'd7);
    after_edge();
    check("dual_pcard3", 32'(bus.pcard3), 32'd7);
    check("dual_dcard3", 32'(bus.dcard3), 32'd7);

    // Reset mid-hand wins over a same-edge load.
    drive(1'b1, 6'b0, 1'b0, 4'd0);
    drive(1'b0, 6'b000001, 1'b1, 4'd1);
    drive(1'b0, 6'b001000, 1'b1, 4'd2);
    drive(1'b0, 6'b000010, 1'b1, 4'd3);
    drive(1'b1, 6'b010000, 1'b1, 4'd5);
    after_edge();
    check("midreset_dcard2", 32'(bus.dcard2), 32'd0);
    check("midreset_dealt",  32'(bus.cards_dealt), 32'd0);

    // Out-of-range forced ranks deal as an ace.
    drive(1'b0, 6'b000001, 1'b1, 4'd0);
    drive(1'b0, 6'b000010, 1'b1, 4'd15);
    after_edge();
    check("badrank0_pcard1",  32'(bus.pcard1), 32'd1);
    check("badrank15_pcard2", 32'(bus.pcard2), 32'd1);

    // Counter dealing on the 5th edge after release.
    drive(1'b1, 6'b0, 1'b0, 4'd0);
    repeat (4) idle();
    drive(1'b0, 6'b000001, 1'b0, 4'd0);
    after_edge();
    check("counter_deal5", 32'(bus.pcard1), 32'd5);

    // Random hands: sparse strobes, occasional resets, mixed deal sources.
    for (int n = 0; n < 600; n++) begin
      logic       r;
      logic [5:0] ld;
      r = ($urandom_range(0, 29) == 0);
      for (int b = 0; b < 6; b++) ld[b] = ($urandom_range(0, 5) == 0);
      drive(r, ld, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    begin
      int wait_cycles = 0;
      while (exp_q.size() > 0 && wait_cycles < 10) begin
        @(negedge clk);
        wait_cycles++;
      end
      #1;
      if (exp_q.size() > 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
